pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter: STALL_W, default 6, stall vector width (bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB).
REQ-002 Parameter: MC_CNT_W, default 6, width of multi-cycle EX operation length.
REQ-003 Parameter: FLUSH_CYCLES, default 1, number of cycles flush is held after an exception (1..7).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 stallreq_id  input  1  ID stage stall request (load-use hazard).
REQ-007 stallreq_ex  input  1  EX stage stall request (single-cycle hold).
REQ-008 stallreq_mem  input  1  MEM stage stall request (data bus not ready).
REQ-009 ex_mc_start  input  1  EX begins a multi-cycle operation (mul/div), one-cycle pulse.
REQ-010 ex_mc_cycles  input  MC_CNT_W  total EX occupancy in cycles, sampled with ex_mc_start.
REQ-011 excp_req  input  1  exception/redirect request, one-cycle pulse.
REQ-012 excp_pc  input  32  redirect target, sampled with excp_req.
REQ-013 stall  output  STALL_W  per-stage hold vector; bit=1 holds that stage.
REQ-014 flush  output  1  clears IF..MEM pipeline registers.
REQ-015 new_pc  output  32  PC load value, valid while flush=1.
REQ-016 mc_busy  output  1  multi-cycle EX operation in progress.

Function
REQ-017 States: RUN, MC, FLUSH; state register only; stall and flush are combinational from state and requests.
REQ-018 Stall priority in RUN: stallreq_mem -> 6'b011111; else stallreq_ex -> 6'b001111; else stallreq_id -> 6'b000111; else 6'b000000.
REQ-019 RUN, ex_mc_start with ex_mc_cycles=N>=2: stall is at least 6'b001111 this cycle; counter loads N-2; next state MC.
REQ-020 RUN, ex_mc_start with N=1: stall 6'b001111 for that cycle only; remain RUN; with N=0: start ignored.
REQ-021 MC: stall = 6'b011111 if stallreq_mem, else 6'b001111; mc_busy=1; counter decrements each cycle; at counter=0, next state RUN (EX held exactly N cycles total, extended by nothing else).
REQ-022 ex_mc_start while in MC or FLUSH is ignored.
REQ-023 excp_req in RUN or MC: highest priority; excp_pc latched into new_pc register; counter loaded FLUSH_CYCLES-1; next state FLUSH; any MC operation is aborted.
REQ-024 excp_req cycle itself: stall=6'b000000 (overrides all requests), flush=0.
REQ-025 FLUSH: flush=1, stall=6'b000000, new_pc stable; counter decrements; at counter=0 next state RUN; excp_req ignored.
REQ-026 new_pc retains last latched value outside FLUSH.
REQ-027 Stall vector always monotonic: if bit k set, all bits below k set.

Reset
REQ-028 rst=0 forces immediately: state RUN, counter 0, new_pc 32'h0, mc_busy 0; stall 6'b000000 and flush 0 while held (requests ignored during reset).
REQ-029 Reset asserted mid-MC or mid-FLUSH abandons the operation; first cycle after release is RUN.

Structure
REQ-030 Stall vector encodings, Stop/NoStop, and state codes are defined in the shared define.v include.
REQ-031 One sub-module: stall_prio, combinational request-to-stall-vector priority encoder; FSM and counter live in pipe_ctrl.

Verification
REQ-032 stallreq_id=1 and stallreq_mem=1 same cycle in RUN -> stall=6'b011111, flush=0.
REQ-033 ex_mc_start, ex_mc_cycles=5 -> stall=6'b001111 for exactly 5 cycles, mc_busy=1 for the last 4, then stall=0.
REQ-034 During MC (cycle 3 of 5) excp_req with excp_pc=32'hBFC00380 -> stall=0 that cycle; next cycle flush=1, new_pc=32'hBFC00380 for FLUSH_CYCLES cycles; mc_busy=0.
REQ-035 excp_req during FLUSH with a different excp_pc -> ignored; new_pc unchanged; returns to RUN on schedule.
REQ-036 rst pulled low during MC -> stall=0, mc_busy=0 immediately (asynchronously); after release, stallreq_ex=1 -> stall=6'b001111.
REQ-037 ex_mc_start with ex_mc_cycles=0 and =1 -> no stall, and stall=6'b001111 for one cycle, respectively; mc_busy never set.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Stall levels count how many low-order stages are held.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_MC    = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam int LVL_NONE = 0;
  localparam int LVL_ID   = 3;
  localparam int LVL_EX   = 4;
  localparam int LVL_MEM  = 5;

  typedef struct packed {
    logic id;
    logic ex;
    logic mem;
    logic kill;
  } stall_req_t;

endpackage

// File: rtl/pipe_ctrl_stall_prio.sv
// Request-to-stall-vector priority encoder.
// Output is always a run of ones from bit 0 upward.
module stall_prio
  import pipe_ctrl_pkg::*;
#(
  parameter int STALL_W = 6
) (
  input  stall_req_t         req,
  output logic [STALL_W-1:0] stall
);

  int lvl;

  always_comb begin
    lvl = LVL_NONE;
    if (req.kill)     lvl = LVL_NONE;
    else if (req.mem) lvl = LVL_MEM;
    else if (req.ex)  lvl = LVL_EX;
    else if (req.id)  lvl = LVL_ID;
  end

  always_comb begin
    stall = '0;
    for (int k = 0; k < STALL_W; k++) begin
      stall[k] = (k < lvl) ? STOP : NO_STOP;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: RUN, multi-cycle EX hold
// and exception flush sequencing.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int STALL_W      = 6,
  parameter int MC_CNT_W     = 6,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stallreq_id,
  input  logic                stallreq_ex,
  input  logic                stallreq_mem,
  input  logic                ex_mc_start,
  input  logic [MC_CNT_W-1:0] ex_mc_cycles,
  input  logic                excp_req,
  input  logic [31:0]         excp_pc,
  output logic [STALL_W-1:0]  stall,
  output logic                flush,
  output logic [31:0]         new_pc,
  output logic                mc_busy
);

  localparam int CNT_W = (MC_CNT_W > 3) ? MC_CNT_W : 3;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      pc_q, pc_d;
  stall_req_t       req;
  logic             mc_go;
  logic             mc_long;
  logic             cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    req     = '{id: stallreq_id, ex: stallreq_ex,
                mem: stallreq_mem, kill: ~rst};
    mc_go   = ex_mc_start && (ex_mc_cycles != '0);
    mc_long = ex_mc_start && (ex_mc_cycles > MC_CNT_W'(1));

    // An exception outranks every request and aborts any EX hold.
    if (excp_req && (state_q != ST_FLUSH)) begin
      req.kill = 1'b1;
      pc_d     = excp_pc;
      cnt_d    = CNT_W'(FLUSH_CYCLES - 1);
      state_d  = ST_FLUSH;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          req.ex = stallreq_ex | mc_go;
          if (mc_long) begin
            cnt_d   = CNT_W'(ex_mc_cycles) - CNT_W'(2);
            state_d = ST_MC;
          end
        end
        ST_MC: begin
          req.ex = 1'b1;
          if (cnt_zero) state_d = ST_RUN;
          else          cnt_d   = cnt_q - CNT_W'(1);
        end
        ST_FLUSH: begin
          req.kill = 1'b1;
          if (cnt_zero) state_d = ST_RUN;
          else          cnt_d   = cnt_q - CNT_W'(1);
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      pc_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
    end
  end

  stall_prio #(
    .STALL_W(STALL_W)
  ) u_prio (
    .req  (req),
    .stall(stall)
  );

  assign flush   = rst && (state_q == ST_FLUSH);
  assign mc_busy = (state_q == ST_MC);
  assign new_pc  = pc_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus
// randomized traffic against a cycle-count reference model.
module tb_pipe_ctrl;

  localparam int FC = 2;

  logic        clk;
  logic        rst;
  logic        stallreq_id, stallreq_ex, stallreq_mem;
  logic        ex_mc_start;
  logic [5:0]  ex_mc_cycles;
  logic        excp_req;
  logic [31:0] excp_pc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        mc_busy;

  int total;
  int bad;

  pipe_ctrl #(
    .STALL_W     (6),
    .MC_CNT_W    (6),
    .FLUSH_CYCLES(FC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stallreq_id (stallreq_id),
    .stallreq_ex (stallreq_ex),
    .stallreq_mem(stallreq_mem),
    .ex_mc_start (ex_mc_start),
    .ex_mc_cycles(ex_mc_cycles),
    .excp_req    (excp_req),
    .excp_pc     (excp_pc),
    .stall       (stall),
    .flush       (flush),
    .new_pc      (new_pc),
    .mc_busy     (mc_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    stallreq_id  = 1'b0;
    stallreq_ex  = 1'b0;
    stallreq_mem = 1'b0;
    ex_mc_start  = 1'b0;
    ex_mc_cycles = 6'd0;
    excp_req     = 1'b0;
    excp_pc      = 32'h0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [39:0] got;
    idle();
    rst = 1'b0;
    stallreq_mem = 1'b1;
    ex_mc_start  = 1'b1;
    ex_mc_cycles = 6'd4;
    excp_req     = 1'b1;
    excp_pc      = 32'h1234_5678;
    next();
    got = {stall, flush, mc_busy, new_pc};
    total++;
    if (got !== 40'h0) begin
      bad++;
      $display("FAIL reset_held got=%h want=0", got);
    end
    idle();
    rst = 1'b1;
    @(negedge clk);
    got = {stall, flush, mc_busy, new_pc};
    total++;
    if (got !== 40'h0) begin
      bad++;
      $display("FAIL reset_release got=%h want=0", got);
    end
    next();
  endtask

  task automatic test_prio();
    logic [5:0] want;
    for (int i = 0; i < 8; i++) begin
      idle();
      {stallreq_id, stallreq_ex, stallreq_mem} = 3'(i);
      want = stallreq_mem ? 6'd31 : stallreq_ex ? 6'd15 :
             stallreq_id ? 6'd7 : 6'd0;
      @(negedge clk);
      total++;
      if ({stall, flush} !== {want, 1'b0}) begin
        bad++;
        $display("FAIL prio_%0d stall=%b flush=%b want=%b/0",
                 i, stall, flush, want);
      end
      next();
    end
    idle();
  endtask

  task automatic test_mc5();
    idle();
    ex_mc_start  = 1'b1;
    ex_mc_cycles = 6'd5;
    for (int c = 0; c < 6; c++) begin
      logic [5:0] ws;
      logic       wb;
      ws = (c < 5) ? 6'd15 : 6'd0;
      wb = (c >= 1 && c < 5);
      if (c == 2) stallreq_mem = 1'b1;
      if (c == 2) ws = 6'd31;
      @(negedge clk);
      total++;
      if ({stall, mc_busy} !== {ws, wb}) begin
        bad++;
        $display("FAIL mc5_c%0d stall=%b busy=%b want=%b/%b",
                 c, stall, mc_busy, ws, wb);
      end
      next();
      idle();
    end
  endtask

  task automatic test_mc_excp();
    idle();
    ex_mc_start  = 1'b1;
    ex_mc_cycles = 6'd5;
    next();
    idle();
    next();
    excp_req     = 1'b1;
    excp_pc      = 32'hBFC0_0380;
    stallreq_mem = 1'b1;
    @(negedge clk);
    total++;
    if ({stall, flush} !== 7'b0) begin
      bad++;
      $display("FAIL excp_cycle stall=%b flush=%b want=0/0",
               stall, flush);
    end
    next();
    idle();
    for (int c = 0; c < FC; c++) begin
      if (c == 0) begin
        excp_req     = 1'b1;
        excp_pc      = 32'h0000_1111;
        stallreq_mem = 1'b1;
      end
      @(negedge clk);
      total++;
      if ({stall, flush, mc_busy, new_pc} !==
          {6'd0, 1'b1, 1'b0, 32'hBFC0_0380}) begin
        bad++;
        $display("FAIL flush_c%0d stall=%b fl=%b busy=%b pc=%h",
                 c, stall, flush, mc_busy, new_pc);
      end
      next();
      idle();
    end
    stallreq_ex = 1'b1;
    @(negedge clk);
    total++;
    if ({stall, flush, new_pc} !== {6'd15, 1'b0, 32'hBFC0_0380}) begin
      bad++;
      $display("FAIL after_flush stall=%b fl=%b pc=%h", stall, flush,
               new_pc);
    end
    next();
    idle();
  endtask

  task automatic test_mc_short();
    idle();
    ex_mc_start  = 1'b1;
    ex_mc_cycles = 6'd0;
    @(negedge clk);
    total++;
    if ({stall, mc_busy} !== 7'b0) begin
      bad++;
      $display("FAIL mc_n0 stall=%b busy=%b want=0/0", stall, mc_busy);
    end
    next();
    ex_mc_cycles = 6'd1;
    @(negedge clk);
    total++;
    if ({stall, mc_busy} !== {6'd15, 1'b0}) begin
      bad++;
      $display("FAIL mc_n1 stall=%b busy=%b want=001111/0",
               stall, mc_busy);
    end
    next();
    idle();
    @(negedge clk);
    total++;
    if ({stall, mc_busy} !== 7'b0) begin
      bad++;
      $display("FAIL mc_n1_after stall=%b busy=%b want=0/0",
               stall, mc_busy);
    end
    next();
  endtask

  task automatic test_reset_mid_mc();
    idle();
    ex_mc_start  = 1'b1;
    ex_mc_cycles = 6'd10;
    next();
    idle();
    @(negedge clk);
    total++;
    if (mc_busy !== 1'b1) begin
      bad++;
      $display("FAIL rst_mc_pre busy=%b want=1", mc_busy);
    end
    #1;
    stallreq_mem = 1'b1;
    rst = 1'b0;
    #1;
    total++;
    if ({stall, flush, mc_busy} !== 8'b0) begin
      bad++;
      $display("FAIL rst_mc_async stall=%b fl=%b busy=%b want=0",
               stall, flush, mc_busy);
    end
    next();
    rst = 1'b1;
    idle();
    stallreq_ex = 1'b1;
    @(negedge clk);
    total++;
    if ({stall, mc_busy} !== {6'd15, 1'b0}) begin
      bad++;
      $display("FAIL rst_mc_after stall=%b busy=%b want=001111/0",
               stall, mc_busy);
    end
    next();
    idle();
  endtask

  task automatic test_random();
    int          mc_left;
    int          fl_left;
    int          lv;
    logic [31:0] pc_m;
    logic [31:0] epc;
    logic [5:0]  es;
    logic        ef;
    logic        eb;
    mc_left = 0;
    fl_left = 0;
    pc_m    = 32'h0;
    for (int i = 0; i < 400; i++) begin
      stallreq_id  = ($urandom_range(0, 3) == 0);
      stallreq_ex  = ($urandom_range(0, 3) == 0);
      stallreq_mem = ($urandom_range(0, 3) == 0);
      ex_mc_start  = ($urandom_range(0, 9) == 0);
      ex_mc_cycles = 6'($urandom_range(0, 8));
      excp_req     = ($urandom_range(0, 19) == 0);
      excp_pc      = $urandom;
      epc = pc_m;
      eb  = 1'b0;
      ef  = 1'b0;
      es  = 6'd0;
      if (fl_left > 0) begin
        ef = 1'b1;
        fl_left--;
      end else if (excp_req) begin
        eb      = (mc_left > 0);
        pc_m    = excp_pc;
        fl_left = FC;
        mc_left = 0;
      end else if (mc_left > 0) begin
        es = stallreq_mem ? 6'd31 : 6'd15;
        eb = 1'b1;
        mc_left--;
      end else begin
        if (stallreq_mem) lv = 5;
        else if (stallreq_ex || (ex_mc_start && ex_mc_cycles >= 1)) lv = 4;
        else if (stallreq_id) lv = 3;
        else lv = 0;
        es = 6'((1 << lv) - 1);
        if (ex_mc_start && ex_mc_cycles >= 2)
          mc_left = int'(ex_mc_cycles) - 1;
      end
      @(negedge clk);
      total++;
      if ({stall, flush, mc_busy, new_pc} !== {es, ef, eb, epc}) begin
        bad++;
        $display("FAIL rand_%0d got=%b/%b/%b/%h want=%b/%b/%b/%h", i,
                 stall, flush, mc_busy, new_pc, es, ef, eb, epc);
      end
      next();
    end
    idle();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    #2;
    test_reset();
    test_prio();
    test_mc5();
    test_mc_excp();
    test_mc_short();
    test_reset_mid_mc();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
